// File: rtl/fm_pkg.sv
// rtl/fm_pkg.sv - shared defaults, pixel type and state encoding for the feature-map streamer
package fm_pkg;

    localparam int FM_DEPTH_DEF = 64;
    localparam int FM_WIDTH_DEF = 56;

    typedef logic [15:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VSYNC  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } fm_state_t;

endpackage

// File: rtl/fm_stream_fifo.sv
// rtl/fm_stream_fifo.sv - pixel input buffer with power-of-two depth and synchronous flush
module fm_stream_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // extra pointer bit distinguishes full from empty when the indices match
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    // pointer update; flush empties the buffer without touching storage
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // storage write; contents need no reset because reads are gated by empty
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/fm_streamer.sv
// rtl/fm_streamer.sv - frame-paced pixel streamer; FM_STREAMER_STALL_CNT_EN adds a starvation counter
module fm_streamer
    import fm_pkg::*;
#(
    parameter int FM_DEPTH   = FM_DEPTH_DEF,
    parameter int FM_WIDTH   = FM_WIDTH_DEF,
    parameter int PERIOD     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               mode_in,
    input  logic                               frame_start,
    input  logic                               pix_in_valid,
    output logic                               pix_in_ready,
    input  logic [$bits(pixel_t)*FM_DEPTH-1:0] pix_in,
    output logic                               verticle_sync,
    output logic                               data_out_valid,
    output logic [$bits(pixel_t)*FM_DEPTH-1:0] data_out,
    output logic                               frame_done,
    output logic                               busy
`ifdef FM_STREAMER_STALL_CNT_EN
    ,
    output logic [15:0]                        stall_cnt
`endif
);

    localparam int DW = $bits(pixel_t) * FM_DEPTH;
    localparam int CW = (FM_WIDTH > 1) ? $clog2(FM_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX   = CW'(FM_WIDTH - 1);
    localparam logic [3:0]    GAP_RELOAD = 4'(PERIOD - 1);

    fm_state_t     state;
    fm_state_t     state_nxt;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic [3:0]    gap;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic          last_pix;

    // buffer keeps accepting in every state so the next frame can prefetch
    assign pix_in_ready = mode_in && !fifo_full;
    assign push         = pix_in_valid && pix_in_ready;
    assign last_pix     = (col == LAST_IDX) && (row == LAST_IDX);

    fm_stream_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .flush (!mode_in),
        .push  (push),
        .pop   (pop),
        .din   (pix_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // next state, pop decision and busy; parameter-load mode overrides everything
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:   if (frame_start) state_nxt = VSYNC;
            VSYNC:  state_nxt = STREAM;
            STREAM: begin
                if (gap == 4'd0 && !fifo_empty) begin
                    pop = 1'b1;
                    if (last_pix) state_nxt = DONE;
                end
            end
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!mode_in) begin
            state_nxt = IDLE;
            pop       = 1'b0;
        end
    end

    // registered outputs, pacing counter and raster position
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn || !mode_in) begin
            verticle_sync  <= 1'b0;
            data_out_valid <= 1'b0;
            data_out       <= '0;
            frame_done     <= 1'b0;
            gap            <= '0;
            col            <= '0;
            row            <= '0;
        end else begin
            verticle_sync  <= (state_nxt == VSYNC);
            data_out_valid <= pop;
            frame_done     <= (state == DONE);
            if (pop) data_out <= fifo_dout;

            if (state != STREAM)   gap <= '0;
            else if (pop)          gap <= GAP_RELOAD;
            else if (gap != 4'd0)  gap <= gap - 4'd1;

            if (state == VSYNC) begin
                col <= '0;
                row <= '0;
            end else if (pop) begin
                if (col == LAST_IDX) begin
                    col <= '0;
                    row <= (row == LAST_IDX) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

`ifdef FM_STREAMER_STALL_CNT_EN
    // cycles in which pacing would allow a pop but the buffer is starved
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
        end else if (!mode_in || state == VSYNC) begin
            stall_cnt <= '0;
        end else if (state == STREAM && gap == 4'd0 && fifo_empty && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fm_streamer.sv
// tb/tb_fm_streamer.sv - directed bench for fm_streamer
module tb_fm_streamer;

    localparam int FM_DEPTH   = 2;
    localparam int FM_WIDTH   = 4;
    localparam int PERIOD     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int DW         = 16 * FM_DEPTH;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          mode_in = 1'b0;
    logic          frame_start = 1'b0;
    logic          pix_in_valid = 1'b0;
    logic [DW-1:0] pix_in = '0;
    logic          pix_in_ready;
    logic          verticle_sync;
    logic          data_out_valid;
    logic [DW-1:0] data_out;
    logic          frame_done;
    logic          busy;
`ifdef FM_STREAMER_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;
    int pushes = 0;
    int pin_idx = 0;
    int gen_cnt = 0;
    int feed_mode = 0;
    int vsyncs = 0;
    int dones = 0;
    int vsync_cyc = -1;
    int done_cyc = -1;
    int base;
    int bad;
    int strobe_cyc[$];
    logic [DW-1:0] push_q[$];
    logic hs;

    fm_streamer #(
        .FM_DEPTH   (FM_DEPTH),
        .FM_WIDTH   (FM_WIDTH),
        .PERIOD     (PERIOD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .mode_in        (mode_in),
        .frame_start    (frame_start),
        .pix_in_valid   (pix_in_valid),
        .pix_in_ready   (pix_in_ready),
        .pix_in         (pix_in),
        .verticle_sync  (verticle_sync),
        .data_out_valid (data_out_valid),
        .data_out       (data_out),
        .frame_done     (frame_done),
        .busy           (busy)
`ifdef FM_STREAMER_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pix_val(input int i);
        return {16'(16'hA000 + i), 16'(i * 3 + 7)};
    endfunction

    function automatic int sc(input int i);
        return (i < strobe_cyc.size()) ? strobe_cyc[i] : -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: record handshake before the edge, observe outputs after it, drive upstream
    task automatic tick();
        logic [DW-1:0] exp_pix;
        @(negedge clk);
        hs = pix_in_valid && pix_in_ready;
        if (hs) begin
            push_q.push_back(pix_in);
            pushes++;
            pin_idx++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (data_out_valid) begin
            strobe_cyc.push_back(cyc);
            exp_pix = (push_q.size() != 0) ? push_q.pop_front() : 'x;
            chk("strobe_data", 64'(data_out), 64'(exp_pix));
        end
        if (verticle_sync) begin
            vsyncs++;
            vsync_cyc = cyc;
        end
        if (frame_done) begin
            dones++;
            done_cyc = cyc;
        end
        case (feed_mode)
            1: pix_in_valid = 1'b1;
            2: begin
                if (hs) gen_cnt = 19;
                else if (gen_cnt > 0) gen_cnt--;
                pix_in_valid = (gen_cnt == 0);
            end
            default: pix_in_valid = 1'b0;
        endcase
        pix_in = pix_val(pin_idx);
    endtask

    task automatic new_scn();
        cyc = 0;
        strobe_cyc.delete();
        vsyncs = 0;
        dones = 0;
        vsync_cyc = -1;
        done_cyc = -1;
    endtask

    task automatic flush();
        feed_mode = 0;
        pix_in_valid = 1'b0;
        mode_in = 1'b0;
        tick();
        push_q.delete();
        mode_in = 1'b1;
    endtask

    task automatic start_frame_at_10();
        while (cyc < 10) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst_dv", 64'(data_out_valid), 64'd0);
        chk("rst_data", 64'(data_out), 64'd0);
        chk("rst_vsync", 64'(verticle_sync), 64'd0);
        chk("rst_done", 64'(frame_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rstn = 1'b1;
        mode_in = 1'b1;
        #1;
        chk("rst_ready", 64'(pix_in_ready), 64'd1);

        // prefill, nominal frame timing, frame_start re-pulse ignored
        new_scn();
        pushes = 0;
        feed_mode = 1;
        pix_in_valid = 1'b1;
        pix_in = pix_val(pin_idx);
        while (cyc < 3) tick();
        chk("pushes_c3", 64'(pushes), 64'd3);
        chk("ready_c3", 64'(pix_in_ready), 64'd1);
        tick();
        chk("pushes_c4", 64'(pushes), 64'd4);
        chk("ready_full", 64'(pix_in_ready), 64'd0);
        start_frame_at_10();
        chk("vsync_cyc", 64'(vsync_cyc), 64'd11);
        chk("busy_vsync", 64'(busy), 64'd1);
        while (cyc < 50) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        while (cyc < 150) tick();
        chk("f1_strobes", 64'(strobe_cyc.size()), 64'd16);
        chk("f1_s1", 64'(sc(0)), 64'd13);
        chk("f1_s2", 64'(sc(1)), 64'd21);
        chk("f1_s3", 64'(sc(2)), 64'd29);
        chk("f1_s16", 64'(sc(15)), 64'd133);
        chk("f1_vsyncs", 64'(vsyncs), 64'd1);
        chk("f1_dones", 64'(dones), 64'd1);
        chk("f1_done_cyc", 64'(done_cyc), 64'd134);
        chk("f1_busy_end", 64'(busy), 64'd0);

        // slow upstream, one pixel every 20 cycles
        flush();
        new_scn();
        feed_mode = 2;
        gen_cnt = 0;
        pix_in_valid = 1'b1;
        pix_in = pix_val(pin_idx);
        start_frame_at_10();
        while (cyc < 330) tick();
        chk("f2_strobes", 64'(strobe_cyc.size()), 64'd16);
        chk("f2_s1", 64'(sc(0)), 64'd13);
        chk("f2_s2", 64'(sc(1)), 64'd22);
        chk("f2_s3", 64'(sc(2)), 64'd42);
        chk("f2_s16", 64'(sc(15)), 64'd302);
        chk("f2_done_cyc", 64'(done_cyc), 64'd303);
        bad = 0;
        for (int i = 2; i < 16; i++) begin
            if (sc(i) - sc(i - 1) != 20) bad++;
        end
        chk("f2_spacing20", 64'(bad), 64'd0);
`ifdef FM_STREAMER_STALL_CNT_EN
        chk("f2_stall_cnt", 64'(stall_cnt), 64'd169);
`endif

        // mode_in dropped at strobe 7
        flush();
        new_scn();
        feed_mode = 1;
        pix_in_valid = 1'b1;
        pix_in = pix_val(pin_idx);
        start_frame_at_10();
        while (strobe_cyc.size() < 7 && cyc < 200) tick();
        chk("f3_s7_cyc", 64'(sc(6)), 64'd61);
        mode_in = 1'b0;
        tick();
        chk("f3_busy", 64'(busy), 64'd0);
        chk("f3_dv", 64'(data_out_valid), 64'd0);
        chk("f3_data", 64'(data_out), 64'd0);
        chk("f3_vsync", 64'(verticle_sync), 64'd0);
        chk("f3_done", 64'(frame_done), 64'd0);
        chk("f3_ready", 64'(pix_in_ready), 64'd0);
        push_q.delete();
        mode_in = 1'b1;
        feed_mode = 0;
        pix_in_valid = 1'b0;
        base = strobe_cyc.size();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (20) tick();
        chk("f3_fifo_empty", 64'(strobe_cyc.size() - base), 64'd0);
        chk("f3_waiting", 64'(busy), 64'd1);
        chk("f3_no_done", 64'(dones), 64'd0);
        mode_in = 1'b0;
        tick();
        mode_in = 1'b1;
        chk("f3_idle", 64'(busy), 64'd0);

        // asynchronous reset mid-frame
        new_scn();
        feed_mode = 1;
        pix_in_valid = 1'b1;
        pix_in = pix_val(pin_idx);
        start_frame_at_10();
        while (strobe_cyc.size() < 3 && cyc < 100) tick();
        chk("f4_pre_dv", 64'(data_out_valid), 64'd1);
        feed_mode = 0;
        pix_in_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("f4_dv", 64'(data_out_valid), 64'd0);
        chk("f4_data", 64'(data_out), 64'd0);
        chk("f4_busy", 64'(busy), 64'd0);
        chk("f4_vsync", 64'(verticle_sync), 64'd0);
        chk("f4_done", 64'(frame_done), 64'd0);
        repeat (2) tick();
        push_q.delete();
        rstn = 1'b1;
        #1;
        chk("f4_ready", 64'(pix_in_ready), 64'd1);
        repeat (3) tick();
        chk("f4_idle_dv", 64'(data_out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
